// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer.
// Face code, FSM state, LFSR seed/taps and the auto-roll idle threshold.
package dice_pkg;

  typedef logic [2:0] face_t;

  typedef enum logic {
    IDLE,
    ROLL
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int AUTO_IDLE_TICKS = 512;

  // Right-shifting Galois step; a non-zero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // A repeat of the current face is bumped so each update is visible.
  function automatic face_t face_next(
    input face_t cur,
    input face_t rnd
  );
    return (rnd == cur) ? cur + 3'd1 : rnd;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and tick-sampled debouncer for an active-low button.
// Ports: clk, rst (async high), tick, btn_n -> btn_db (1 = pressed), press.
module btn_debounce #(
  parameter int DEB_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_n,
  output logic btn_db,
  output logic press
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_btn_s;
  logic          w_mis;

  assign w_btn_s = ~r_sync2;
  assign w_mis   = (w_btn_s != r_db);
  assign btn_db  = r_db;
  assign press   = r_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_db    <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (tick) begin
        if (w_mis) begin
          if (r_cnt == CW'(DEB_TICKS - 1)) begin
            r_db    <= w_btn_s;
            r_cnt   <= '0;
            // Pulse coincides with the level going to pressed.
            r_press <= w_btn_s;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll sequencer: debounced press starts a slowing random face animation.
// Ports: clk, rst (async high), btn_n -> face[2:0], rolling, done (1-cycle).
// Optional: DICE_ROLL_AUTO_EN starts a roll after AUTO_IDLE_TICKS idle ticks.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TICK_DIV   = 250000,
  parameter int DEB_TICKS  = 2,
  parameter int ROLL_STEPS = 12
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_n,
  output face_t face,
  output logic  rolling,
  output logic  done
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] r_tick_cnt;
  logic [15:0]   r_lfsr;
  state_t        r_state;
  logic [5:0]    r_step;
  logic [4:0]    r_wait;
  face_t         r_face;
  logic          r_rolling;
  logic          r_done;

  logic  w_tick;
  logic  w_btn_db;
  logic  w_press;
  logic  w_auto;
  logic  w_start;
  logic  w_wait_last;
  face_t w_nxt;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Free-running so the moment of the press seeds the outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  btn_debounce #(
    .DEB_TICKS(DEB_TICKS)
  ) u_deb (
    .clk   (clk),
    .rst   (rst),
    .tick  (w_tick),
    .btn_n (btn_n),
    .btn_db(w_btn_db),
    .press (w_press)
  );

`ifdef DICE_ROLL_AUTO_EN
  localparam int IW = $clog2(AUTO_IDLE_TICKS);

  logic [IW-1:0] r_idle_cnt;

  assign w_auto = (r_state == IDLE) && w_tick &&
                  (r_idle_cnt == IW'(AUTO_IDLE_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != IDLE || w_press || w_auto) begin
      r_idle_cnt <= '0;
    end else if (w_tick) begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end
`else
  assign w_auto = 1'b0;
`endif

  // Press pulse and settled level rise together.
  assign w_start     = (w_press & w_btn_db) | w_auto;
  // interval - 1 == step >> 2
  assign w_wait_last = (r_wait == 5'(r_step >> 2));
  assign w_nxt       = face_next(r_face, r_lfsr[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_wait    <= '0;
      r_face    <= '0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= ROLL;
            r_step    <= '0;
            r_wait    <= '0;
            r_rolling <= 1'b1;
          end
        end
        ROLL: begin
          if (w_tick) begin
            if (w_wait_last) begin
              r_face <= w_nxt;
              r_wait <= '0;
              r_step <= r_step + 6'd1;
              if (r_step == 6'(ROLL_STEPS - 1)) begin
                r_done    <= 1'b1;
                r_state   <= IDLE;
                r_rolling <= 1'b0;
              end
            end else begin
              r_wait <= r_wait + 5'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign face    = r_face;
  assign rolling = r_rolling;
  assign done    = r_done;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl (TICK_DIV=4, DEB_TICKS=2, ROLL_STEPS=5).
// Stimulus queues expected rolls; a negedge monitor checks faces and timing.
module tb_dice_roll_ctrl;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int RS = 5;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic [2:0] face;
  logic       rolling;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  dice_roll_ctrl #(
    .TICK_DIV  (TD),
    .DEB_TICKS (DB),
    .ROLL_STEPS(RS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_n),
    .face   (face),
    .rolling(rolling),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR and tick phase, per the described behaviour.
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  int          m_tcnt;
  logic        m_tick_edge;
  int          cyc = 0;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr      <= 16'hACE1;
      m_prev      <= 16'hACE1;
      m_tcnt      <= 0;
      m_tick_edge <= 1'b0;
    end else begin
      m_prev      <= m_lfsr;
      m_lfsr      <= ref_step(m_lfsr);
      m_tick_edge <= (m_tcnt == TD - 1);
      m_tcnt      <= (m_tcnt == TD - 1) ? 0 : m_tcnt + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  int exp_q[$];
  int rolls_seen = 0;
  int done_seen  = 0;
  int mon_nchg   = 0;

  // Monitor
  initial begin
    logic [2:0] prev_face;
    logic       prev_roll;
    logic       act;
    int         n_exp;
    int         last_cyc;
    logic [2:0] rnd;
    logic [2:0] expf;
    int         gap;
    prev_face = 3'd0;
    prev_roll = 1'b0;
    act       = 1'b0;
    n_exp     = RS;
    last_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act       = 1'b0;
        prev_face = face;
        prev_roll = rolling;
      end else begin
        if (rolling && !prev_roll) begin
          rolls_seen++;
          chk("roll_expected", int'(exp_q.size() > 0), 1);
          n_exp    = (exp_q.size() > 0) ? exp_q.pop_front() : RS;
          act      = 1'b1;
          mon_nchg = 0;
          last_cyc = cyc;
        end
        if (face != prev_face) begin
          rnd  = m_prev[2:0];
          expf = (rnd == prev_face) ? prev_face + 3'd1 : rnd;
          chk("face_value", int'(face), int'(expf));
          chk("change_in_roll", int'(act), 1);
          chk("change_on_tick", int'(m_tick_edge), 1);
          gap = cyc - last_cyc;
          if (mon_nchg == 0) begin
            chk("first_change_latency", int'(gap >= 1 && gap <= TD), 1);
          end else begin
            chk("change_gap", gap, (1 + (mon_nchg >> 2)) * TD);
          end
          mon_nchg++;
          last_cyc = cyc;
          chk("done_with_last", int'(done), int'(mon_nchg == n_exp));
        end else if (done) begin
          chk("done_without_change", 0, 1);
        end
        if (done) done_seen++;
        if (!rolling && prev_roll && act) begin
          chk("roll_changes", mon_nchg, n_exp);
          act = 1'b0;
        end
        prev_face = face;
        prev_roll = rolling;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic roll_press(input int hold, input int rel);
    exp_q.push_back(RS);
    btn_n = 1'b0;
    cycles(hold);
    btn_n = 1'b1;
    cycles(rel);
  endtask

  initial begin
    logic [2:0] f0;
    rst   = 1'b1;
    btn_n = 1'b1;
    #12;
    chk("reset_face", int'(face), 0);
    chk("reset_rolling", int'(rolling), 0);
    chk("reset_done", int'(done), 0);
    #10 rst = 1'b0;

    // 1: idle with button released
    cycles(1000);
    chk("idle_face", int'(face), 0);
    chk("idle_rolling", int'(rolling), 0);
    chk("idle_done_count", done_seen, 0);
    chk("idle_roll_count", rolls_seen, 0);

    // 2/3: single press and release
    roll_press(60, 40);
    chk("t2_rolls", rolls_seen, 1);
    chk("t2_dones", done_seen, 1);
    chk("t2_queue_empty", exp_q.size(), 0);
    chk("t2_rolling_low", int'(rolling), 0);
    f0 = face;
    cycles(20);
    chk("t2_face_hold", int'(face), int'(f0));

    // 4: bounce shorter than the debounce window
    for (int k = 0; k < 8 && m_tcnt != 0; k++) cycles(1);
    for (int i = 0; i < 6; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(1);
    end
    btn_n = 1'b1;
    cycles(40);
    chk("t4_no_roll", rolls_seen, 1);
    chk("t4_rolling_low", int'(rolling), 0);

    // 5: held button gives one roll, release then re-press gives another
    roll_press(110, 20);
    chk("t5_single_roll", rolls_seen, 2);
    chk("t5_dones", done_seen, 2);
    roll_press(60, 30);
    chk("t5_second_roll", rolls_seen, 3);
    chk("t5_dones2", done_seen, 3);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: asynchronous reset during step 3
    exp_q.push_back(RS);
    btn_n = 1'b0;
    for (int k = 0; k < 200 && !(rolling && mon_nchg >= 3); k++)
      cycles(1);
    chk("t6_reached_step3", int'(rolling && mon_nchg == 3), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_abort_face", int'(face), 0);
    chk("t6_abort_rolling", int'(rolling), 0);
    chk("t6_abort_done", int'(done), 0);
    btn_n = 1'b1;
    cycles(3);
    #1 rst = 1'b0;
    cycles(2);
    chk("t6_no_done_on_abort", done_seen, 3);
    chk("t6_rolls", rolls_seen, 4);
    roll_press(60, 30);
    chk("t6_after_rolls", rolls_seen, 5);
    chk("t6_after_dones", done_seen, 4);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_rolling_low", int'(rolling), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
